// File: rtl/nt_node_monitor.sv
// Observation-window monitor for one internal node: compacts the sampled stream
// into a 16-bit MISR signature and counts ones/toggles to flag rarely-active nodes.
module nt_node_monitor (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        start,
    input  logic [15:0] win_len,
    input  logic [15:0] rare_thr,
    input  logic        node_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] sig_out,
    output logic [15:0] ones_cnt,
    output logic [15:0] toggle_cnt,
    output logic        rare_flag
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [15:0] win_len;
        logic [15:0] rare_thr;
    } cfg_t;

    state_t      state_q, state_d;
    cfg_t        cfg_q;
    logic [15:0] sig_q, ones_q, tog_q, scnt_q;
    logic        prev_q, rare_q;

    logic        accept, last;
    logic        fb;
    logic [15:0] sig_step, ones_step, tog_step;

    // start is only honoured outside RUN, so a window can never be cut short
    assign accept = start && (state_q != RUN);
    assign last   = (state_q == RUN) && ((scnt_q + 16'd1) == cfg_q.win_len);

    assign fb        = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10] ^ node_in;
    assign sig_step  = {sig_q[14:0], fb};
    assign ones_step = ones_q + {15'd0, node_in};
    assign tog_step  = tog_q + {15'd0, node_in ^ prev_q};

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (win_len == 16'd0) ? DONE : RUN;
            RUN:        if (last)  state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            cfg_q  <= '0;
            sig_q  <= '0;
            ones_q <= '0;
            tog_q  <= '0;
            scnt_q <= '0;
            prev_q <= 1'b0;
            rare_q <= 1'b0;
        end else if (accept) begin
            cfg_q.win_len  <= win_len;
            cfg_q.rare_thr <= rare_thr;
            sig_q  <= '0;
            ones_q <= '0;
            tog_q  <= '0;
            scnt_q <= '0;
            prev_q <= 1'b0;
            // an empty window goes straight to DONE: zero ones is always rare
            rare_q <= (win_len == 16'd0);
        end else if (state_q == RUN) begin
            sig_q  <= sig_step;
            ones_q <= ones_step;
            tog_q  <= tog_step;
            prev_q <= node_in;
            scnt_q <= scnt_q + 16'd1;
            if (last)
                rare_q <= (ones_step <= cfg_q.rare_thr) || (tog_step == 16'd0);
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign sig_out    = sig_q;
    assign ones_cnt   = ones_q;
    assign toggle_cnt = tog_q;
    assign rare_flag  = rare_q;

endmodule

// File: tb/tb_nt_node_monitor.sv
// Randomized and directed bench for nt_node_monitor against a window-level model.
module tb_nt_node_monitor;

    logic        CLK = 1'b0;
    logic        RSTB;
    logic        start;
    logic [15:0] win_len, rare_thr;
    logic        node_in;
    logic        busy, done, rare_flag;
    logic [15:0] sig_out, ones_cnt, toggle_cnt;

    int checks = 0;
    int errors = 0;

    logic        smp [0:63];
    logic [15:0] e_sig, e_ones, e_tog;
    logic        e_rare;

    nt_node_monitor dut (
        .CLK(CLK), .RSTB(RSTB), .start(start), .win_len(win_len), .rare_thr(rare_thr),
        .node_in(node_in), .busy(busy), .done(done), .sig_out(sig_out),
        .ones_cnt(ones_cnt), .toggle_cnt(toggle_cnt), .rare_flag(rare_flag)
    );

    always #5 CLK = ~CLK;

    // Expected results for the first n samples of smp[].
    function automatic void model(input int n, input logic [15:0] thr);
        logic [15:0] s;
        int          o, t;
        logic        p, fb;
        s = 16'd0; o = 0; t = 0; p = 1'b0;
        for (int i = 0; i < n; i++) begin
            fb = (^(s & 16'hB400)) ^ smp[i];
            s  = {s[14:0], fb};
            if (smp[i]) o++;
            if (smp[i] != p) t++;
            p = smp[i];
        end
        e_sig  = s;
        e_ones = o[15:0];
        e_tog  = t[15:0];
        e_rare = (o <= int'(thr)) || (t == 0);
    endfunction

    // All drive tasks start and end at 1 time unit after a rising edge.
    task automatic drive_start(input int n, input logic [15:0] thr);
        start = 1'b1; win_len = 16'(n); rare_thr = thr;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic drive_samples(input int n);
        for (int i = 0; i < n; i++) begin
            node_in = smp[i];
            @(posedge CLK); #1;
        end
        node_in = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, done, rare_flag, sig_out, ones_cnt, toggle_cnt} !== 51'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b rare=%b sig=%h ones=%0d tog=%0d, want all 0",
                     busy, done, rare_flag, sig_out, ones_cnt, toggle_cnt);
        end
        RSTB = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic_window;
        smp[0] = 1; smp[1] = 0; smp[2] = 1; smp[3] = 1;
        drive_start(4, 16'd2);
        drive_samples(3);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_not_early: got busy=%b done=%b after 3 samples, want 1 0", busy, done);
        end
        drive_samples(4 - 3 + 0);
    endtask

    task automatic test_basic;
        smp[0] = 1; smp[1] = 0; smp[2] = 1; smp[3] = 1;
        drive_start(4, 16'd2);
        for (int i = 0; i < 4; i++) begin
            node_in = smp[i];
            @(posedge CLK); #1;
            if (i == 2) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_not_early: got busy=%b done=%b after 3 samples, want 1 0", busy, done);
                end
            end
        end
        node_in = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sig_out !== 16'h000B || ones_cnt !== 16'd3 ||
            toggle_cnt !== 16'd3 || rare_flag !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got done=%b busy=%b sig=%h ones=%0d tog=%0d rare=%b, want 1 0 000b 3 3 0",
                     done, busy, sig_out, ones_cnt, toggle_cnt, rare_flag);
        end
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (done !== 1'b1 || sig_out !== 16'h000B || ones_cnt !== 16'd3 || rare_flag !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: got done=%b sig=%h ones=%0d rare=%b, want 1 000b 3 0",
                     done, sig_out, ones_cnt, rare_flag);
        end
    endtask

    task automatic test_restart_from_done;
        smp[0] = 1; smp[1] = 1;
        drive_start(2, 16'd0);
        checks++;
        if (busy !== 1'b1 || sig_out !== 16'd0 || ones_cnt !== 16'd0 || toggle_cnt !== 16'd0) begin
            errors++;
            $display("FAIL restart_clear: got busy=%b sig=%h ones=%0d tog=%0d, want 1 0000 0 0",
                     busy, sig_out, ones_cnt, toggle_cnt);
        end
        drive_samples(2);
        checks++;
        if (done !== 1'b1 || sig_out !== 16'h0003 || ones_cnt !== 16'd2 || toggle_cnt !== 16'd1 ||
            rare_flag !== 1'b0) begin
            errors++;
            $display("FAIL restart_result: got done=%b sig=%h ones=%0d tog=%0d rare=%b, want 1 0003 2 1 0",
                     done, sig_out, ones_cnt, toggle_cnt, rare_flag);
        end
    endtask

    task automatic test_zero_len;
        drive_start(0, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sig_out !== 16'd0 || ones_cnt !== 16'd0 ||
            toggle_cnt !== 16'd0 || rare_flag !== 1'b1) begin
            errors++;
            $display("FAIL zero_len: got done=%b busy=%b sig=%h ones=%0d tog=%0d rare=%b, want 1 0 0000 0 0 1",
                     done, busy, sig_out, ones_cnt, toggle_cnt, rare_flag);
        end
    endtask

    task automatic test_all_zero;
        for (int i = 0; i < 8; i++) smp[i] = 1'b0;
        drive_start(8, 16'd0);
        drive_samples(8);
        checks++;
        if (done !== 1'b1 || sig_out !== 16'd0 || ones_cnt !== 16'd0 || toggle_cnt !== 16'd0 ||
            rare_flag !== 1'b1) begin
            errors++;
            $display("FAIL all_zero: got done=%b sig=%h ones=%0d tog=%0d rare=%b, want 1 0000 0 0 1",
                     done, sig_out, ones_cnt, toggle_cnt, rare_flag);
        end
    endtask

    task automatic test_start_ignored;
        smp[0] = 1; smp[1] = 1;
        for (int i = 2; i < 6; i++) smp[i] = 1'b0;
        model(6, 16'd3);
        drive_start(6, 16'd3);
        for (int i = 0; i < 6; i++) begin
            node_in = smp[i];
            // re-request with different parameters mid-window
            if (i == 1 || i == 3) begin start = 1'b1; win_len = 16'd2; rare_thr = 16'd0; end
            else start = 1'b0;
            @(posedge CLK); #1;
            if (i == 4) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_busy: got busy=%b done=%b after 5 samples, want 1 0", busy, done);
                end
            end
        end
        start = 1'b0; node_in = 1'b0;
        checks++;
        if (done !== 1'b1 || sig_out !== e_sig || ones_cnt !== e_ones || toggle_cnt !== e_tog ||
            rare_flag !== e_rare) begin
            errors++;
            $display("FAIL ignore_result: got done=%b sig=%h ones=%0d tog=%0d rare=%b, want 1 %h %0d %0d %b",
                     done, sig_out, ones_cnt, toggle_cnt, rare_flag, e_sig, e_ones, e_tog, e_rare);
        end
    endtask

    task automatic test_reset_mid_run;
        for (int i = 0; i < 10; i++) smp[i] = 1'($urandom_range(0, 1));
        smp[0] = 1'b1;
        drive_start(10, 16'd4);
        drive_samples(2);
        node_in = smp[2];
        #2 RSTB = 1'b0;
        #1;
        checks++;
        if ({busy, done, rare_flag, sig_out, ones_cnt, toggle_cnt} !== 51'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b rare=%b sig=%h ones=%0d tog=%0d, want all 0",
                     busy, done, rare_flag, sig_out, ones_cnt, toggle_cnt);
        end
        @(posedge CLK); #1;
        RSTB = 1'b1;
        node_in = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ones_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b done=%b ones=%0d, want 0 0 0", busy, done, ones_cnt);
        end
        model(10, 16'd4);
        drive_start(10, 16'd4);
        drive_samples(10);
        checks++;
        if (done !== 1'b1 || sig_out !== e_sig || ones_cnt !== e_ones || toggle_cnt !== e_tog ||
            rare_flag !== e_rare) begin
            errors++;
            $display("FAIL fresh_window: got done=%b sig=%h ones=%0d tog=%0d rare=%b, want 1 %h %0d %0d %b",
                     done, sig_out, ones_cnt, toggle_cnt, rare_flag, e_sig, e_ones, e_tog, e_rare);
        end
    endtask

    task automatic test_random;
        int          n;
        logic [15:0] thr;
        for (int w = 0; w < 25; w++) begin
            n   = (w % 8 == 7) ? 0 : int'($urandom_range(1, 40));
            thr = 16'($urandom_range(0, n + 2));
            for (int i = 0; i < n; i++) smp[i] = 1'($urandom_range(0, 1));
            drive_start(n, thr);
            for (int i = 0; i < n; i++) begin
                node_in = smp[i];
                @(posedge CLK); #1;
                model(i + 1, thr);
                checks++;
                if (sig_out !== e_sig || ones_cnt !== e_ones || toggle_cnt !== e_tog) begin
                    errors++;
                    $display("FAIL live_w%0d_s%0d: got sig=%h ones=%0d tog=%0d, want %h %0d %0d",
                             w, i, sig_out, ones_cnt, toggle_cnt, e_sig, e_ones, e_tog);
                end
            end
            node_in = 1'b0;
            model(n, thr);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || rare_flag !== e_rare || sig_out !== e_sig) begin
                errors++;
                $display("FAIL rand_end_w%0d: got done=%b busy=%b rare=%b sig=%h, want 1 0 %b %h",
                         w, done, busy, rare_flag, sig_out, e_rare, e_sig);
            end
        end
    endtask

    initial begin
        RSTB = 1'b0; start = 1'b0; win_len = '0; rare_thr = '0; node_in = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        test_reset;
        test_basic;
        test_restart_from_done;
        test_zero_len;
        test_all_zero;
        test_start_ignored;
        test_reset_mid_run;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nt_node_monitor.md
NT_NODE_MONITOR -- requirements
Module: nt_node_monitor

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port RSTB, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port start, input, 1 bit: request to begin an observation window.
REQ-004 The block SHALL have the port win_len, input, 16 bits: number of node samples in the window; latched on accepted start.
REQ-005 The block SHALL have the port rare_thr, input, 16 bits: rare-activity threshold; latched on accepted start.
REQ-006 The block SHALL have the port node_in, input, 1 bit: observed internal-node output of the upstream subcircuit, sampled once per RUN cycle.
REQ-007 The block SHALL have the port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have the port done, output, 1 bit: high while in DONE.
REQ-009 The block SHALL have the port sig_out, output, 16 bits: MISR signature of the sampled stream.
REQ-010 The block SHALL have the port ones_cnt, output, 16 bits: count of samples equal to 1.
REQ-011 The block SHALL have the port toggle_cnt, output, 16 bits: count of sample-to-sample value changes.
REQ-012 The block SHALL have the port rare_flag, output, 1 bit: trojan-trigger candidate indication, valid in DONE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1: latch win_len and rare_thr, clear sig/counters/prev-sample/sample-counter, go to RUN; if latched win_len=0, go to DONE instead.
REQ-015 RUN: each cycle sample node_in, update sig/ones/toggle, increment sample counter; after the win_len-th sample go to DONE on the next edge.
REQ-016 Latency: a window of N samples (N≥1) SHALL occupy exactly N RUN cycles; done rises on the edge after the last sample.
REQ-017 MISR update SHALL be sig_next = {sig[14:0], fb}, where fb = sig[15]^sig[13]^sig[12]^sig[10]^node_in.
REQ-018 ones_cnt SHALL increment when node_in=1; toggle_cnt SHALL increment when node_in differs from the previous sample.
REQ-019 The previous sample SHALL be 0 at window start, so a first sample of 1 counts as one toggle.
REQ-020 Counters cannot exceed win_len ≤ 0xFFFF; no saturation or wrap logic is required.
REQ-021 rare_flag SHALL be registered on entry to DONE as (ones_cnt ≤ rare_thr) OR (toggle_cnt = 0), and held throughout DONE.
REQ-022 DONE: all outputs SHALL hold; start=1 SHALL restart exactly as from IDLE (clear, relatch, go to RUN or DONE).
REQ-023 start SHALL be ignored during RUN; win_len/rare_thr changes after latching SHALL have no effect.
REQ-024 sig_out, ones_cnt and toggle_cnt SHALL be visible live during RUN, updated the cycle after each sample.

Reset
REQ-025 RSTB=0 SHALL asynchronously force IDLE; sig_out, ones_cnt, toggle_cnt = 0; busy, done, rare_flag = 0; latched registers = 0.
REQ-026 Reset asserted mid-RUN SHALL abort the window with no partial result retained; operation resumes only on a new start after RSTB=1.

Verification
REQ-027 win_len=4, rare_thr=2, node_in=1,0,1,1 -> done after 4 RUN cycles; sig_out=0x000B, ones_cnt=3, toggle_cnt=3, rare_flag=0.
REQ-028 win_len=0, start pulse -> done=1 on the next edge; all counts and sig 0; rare_flag=1.
REQ-029 win_len=8, node_in held 0, rare_thr=0 -> ones_cnt=0, toggle_cnt=0, sig_out=0x0000, rare_flag=1.
REQ-030 start re-pulsed during RUN of win_len=6 -> ignored; window ends after 6 samples with unchanged latched rare_thr.
REQ-031 RSTB low at sample 3 of win_len=10 -> all outputs 0 immediately (asynchronously); a subsequent start runs a full fresh window.
REQ-032 In DONE, start with win_len=2, node_in=1,1 -> counters cleared, then ones_cnt=2, toggle_cnt=1, sig_out=0x0003.
